// File: rtl/jmp_sequencer.sv
// Conditional-jump sequencer: fetches a two-byte operand (high byte first), evaluates the
// condition on flags captured at start, then issues one PC-load pulse or an err pulse on fetch timeout.
module jmp_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        cond_sel,
  input  logic              rel,
  input  logic              zflag,
  input  logic              oflag,
  input  logic              cflag,
  input  logic              sflag,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_next,
  output logic              taken,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, FETCH_HI, FETCH_LO, EVAL} state_t;

  state_t            state_q;
  logic [3:0]        sel_q;
  logic              rel_q, z_q, o_q, c_q, s_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        hi_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_req_q, pc_we_q, taken_q, err_q;
  logic [ADDR_W-1:0] mem_addr_q, pc_next_q;

  logic              cond_d;
  logic              timeout_hit_d;
  logic [15:0]       operand_d;
  logic [ADDR_W-1:0] fall_d, target_d;

  function automatic logic cond_eval(input logic [3:0] sel, input logic z, o, c, s);
    logic lt;
    lt = o ^ s;
    case (sel)
      4'd0:    return 1'b1;
      4'd1:    return z;
      4'd2:    return !z;
      4'd3:    return c;
      4'd4:    return c | z;
      4'd5:    return !(c | z);
      4'd6:    return !c;
      4'd7:    return lt;
      4'd8:    return lt | z;
      4'd9:    return !lt & !z;
      4'd10:   return !lt;
      default: return 1'b0;
    endcase
  endfunction

  // The low byte is consumed straight off mem_rdata in its ack cycle, so the
  // result registers load in that same cycle and EVAL presents them.
  assign cond_d        = cond_eval(sel_q, z_q, o_q, c_q, s_q);
  assign operand_d     = {hi_q, mem_rdata};
  assign fall_d        = base_q + ADDR_W'(2);
  assign target_d      = rel_q ? fall_d + ADDR_W'(operand_d) : ADDR_W'(operand_d);
  assign timeout_hit_d = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rel_q      <= 1'b0;
      z_q        <= 1'b0;
      o_q        <= 1'b0;
      c_q        <= 1'b0;
      s_q        <= 1'b0;
      base_q     <= '0;
      hi_q       <= '0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pc_we_q    <= 1'b0;
      pc_next_q  <= '0;
      taken_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pc_we_q   <= 1'b0;
      pc_next_q <= '0;
      taken_q   <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sel_q      <= cond_sel;
            rel_q      <= rel;
            z_q        <= zflag;
            o_q        <= oflag;
            c_q        <= cflag;
            s_q        <= sflag;
            base_q     <= pc;
            cnt_q      <= '0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc;
            state_q    <= FETCH_HI;
          end
        end
        FETCH_HI, FETCH_LO: begin
          if (mem_ack) begin
            cnt_q <= '0;
            if (state_q == FETCH_HI) begin
              hi_q       <= mem_rdata;
              mem_addr_q <= base_q + ADDR_W'(1);
              state_q    <= FETCH_LO;
            end else begin
              mem_req_q  <= 1'b0;
              mem_addr_q <= '0;
              pc_we_q    <= 1'b1;
              taken_q    <= cond_d;
              pc_next_q  <= cond_d ? target_d : fall_d;
              state_q    <= EVAL;
            end
          end else if (timeout_hit_d) begin
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            err_q      <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        EVAL:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign busy     = (state_q != IDLE);
  assign pc_we    = pc_we_q;
  assign pc_next  = pc_next_q;
  assign taken    = taken_q;
  assign err      = err_q;

endmodule

// File: tb/tb_jmp_sequencer.sv
// Randomized bench for jmp_sequencer: a wait-state memory responder plus a
// condition/target reference model computed directly from the jump rules.
module tb_jmp_sequencer;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  cond_sel;
  logic        rel;
  logic        zflag, oflag, cflag, sflag;
  logic [15:0] pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        pc_we;
  logic [15:0] pc_next;
  logic        taken;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_delay = 0;
  logic [7:0] mem [0:65535];

  jmp_sequencer #(.ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .cond_sel(cond_sel), .rel(rel),
    .zflag(zflag), .oflag(oflag), .cflag(cflag), .sflag(sflag), .pc(pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .pc_we(pc_we), .pc_next(pc_next), .taken(taken), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: acks after ack_delay wait cycles of mem_req; noise on ack while idle.
  initial begin
    int wcnt;
    wcnt      = 0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (mem_req) begin
        if (wcnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          wcnt      = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'($urandom);
          wcnt++;
        end
      end else begin
        mem_ack   = 1'($urandom % 2);
        mem_rdata = 8'($urandom);
        wcnt      = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic void model(input int sel, input bit r, z, o, c, s, input int p, hi, lo,
                                output bit tk, output logic [15:0] pcn);
    int off, tgt;
    case (sel)
      0:  tk = 1;
      1:  tk = z;
      2:  tk = !z;
      3:  tk = c;
      4:  tk = c || z;
      5:  tk = !(c || z);
      6:  tk = !c;
      7:  tk = (o != s);
      8:  tk = (o != s) || z;
      9:  tk = (o == s) && !z;
      10: tk = (o == s);
      default: tk = 0;
    endcase
    off = hi * 256 + lo;
    tgt = r ? (p + 2 + off) % 65536 : off;
    pcn = tk ? 16'(tgt) : 16'((p + 2) % 65536);
  endfunction

  // Launches one jump and records what the DUT does until it returns to IDLE.
  task automatic run_jump(input int sel, input bit r, z, o, c, s, input int p, hi, lo, dly,
                          output int lat, output int errk, output int nwe, output int nerr,
                          output int busy_cyc, output int bad,
                          output logic [15:0] pcn, output logic tk);
    logic [15:0] base;
    bit hi_done;
    int k;
    base = 16'(p);
    lat = -1; errk = -1; nwe = 0; nerr = 0; busy_cyc = 0; bad = 0; pcn = 'x; tk = 1'bx;
    hi_done = 0;
    @(negedge clk);
    mem[base] = 8'(hi);
    mem[base + 16'd1] = 8'(lo);
    ack_delay = dly;
    start = 1; cond_sel = 4'(sel); rel = r; pc = base;
    zflag = z; oflag = o; cflag = c; sflag = s;
    @(negedge clk);
    start = 0; zflag = ~z; oflag = ~o; cflag = ~c; sflag = ~s;
    cond_sel = 4'($urandom); rel = ~r; pc = 16'($urandom);
    k = 1;
    while (k <= 60) begin
      if (busy) busy_cyc++;
      if (mem_req) begin
        if (mem_addr !== (hi_done ? base + 16'd1 : base)) bad++;
        if (mem_ack && !hi_done) hi_done = 1;
      end
      if (!pc_we && (pc_next !== 16'h0 || taken !== 1'b0)) bad++;
      if (pc_we) begin nwe++; lat = k; pcn = pc_next; tk = taken; end
      if (err) begin nerr++; errk = k; end
      if (!busy) break;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 0; start = 1; cond_sel = 0; rel = 0; pc = 16'h1234;
    zflag = 1; oflag = 1; cflag = 1; sflag = 1;
    repeat (3) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL reset_pc_we: got %b want 0", pc_we); end
    n_cmp++; if (pc_next !== 16'h0) begin n_fail++; $display("FAIL reset_pc_next: got %h want 0000", pc_next); end
    n_cmp++; if (taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b want 0", taken); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    start = 0; rst = 1;
    @(negedge clk);
  endtask

  task automatic test_abs_always();
    int lat, errk, nwe, nerr, bc, bad; logic [15:0] pcn; logic tk;
    run_jump(0, 0, 0, 0, 0, 0, 'h0100, 'h12, 'h34, 0, lat, errk, nwe, nerr, bc, bad, pcn, tk);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL abs_latency: got %0d want 3", lat); end
    n_cmp++; if (pcn !== 16'h1234) begin n_fail++; $display("FAIL abs_pc_next: got %h want 1234", pcn); end
    n_cmp++; if (tk !== 1'b1) begin n_fail++; $display("FAIL abs_taken: got %b want 1", tk); end
    n_cmp++; if (bc !== 3) begin n_fail++; $display("FAIL abs_busy_cycles: got %0d want 3", bc); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL abs_protocol: got %0d violations want 0", bad); end
    n_cmp++; if (nwe !== 1) begin n_fail++; $display("FAIL abs_pc_we_count: got %0d want 1", nwe); end
  endtask

  task automatic test_rel_wrap();
    int lat, errk, nwe, nerr, bc, bad; logic [15:0] pcn; logic tk;
    run_jump(0, 1, 0, 0, 0, 0, 'hFFF0, 'h00, 'h20, 0, lat, errk, nwe, nerr, bc, bad, pcn, tk);
    n_cmp++; if (pcn !== 16'h0012) begin n_fail++; $display("FAIL rel_wrap_pc_next: got %h want 0012", pcn); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rel_wrap_protocol: got %0d violations want 0", bad); end
  endtask

  task automatic test_not_taken();
    int lat, errk, nwe, nerr, bc, bad; logic [15:0] pcn; logic tk;
    run_jump(1, 0, 0, 0, 0, 0, 'h0200, 'hAB, 'hCD, 0, lat, errk, nwe, nerr, bc, bad, pcn, tk);
    n_cmp++; if (tk !== 1'b0) begin n_fail++; $display("FAIL nt_z_taken: got %b want 0", tk); end
    n_cmp++; if (pcn !== 16'h0202) begin n_fail++; $display("FAIL nt_z_pc_next: got %h want 0202", pcn); end
    run_jump(13, 0, 1, 1, 1, 1, 'h0200, 'hAB, 'hCD, 0, lat, errk, nwe, nerr, bc, bad, pcn, tk);
    n_cmp++; if (pcn !== 16'h0202) begin n_fail++; $display("FAIL nt_illegal_pc_next: got %h want 0202", pcn); end
    n_cmp++; if (tk !== 1'b0) begin n_fail++; $display("FAIL nt_illegal_taken: got %b want 0", tk); end
  endtask

  task automatic test_signed();
    int lat, errk, nwe, nerr, bc, bad; logic [15:0] pcn; logic tk;
    int sels [4] = '{7, 8, 9, 10};
    bit exp  [4] = '{1, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      run_jump(sels[i], 0, 0, 1, 0, 0, 'h0300, 'h45, 'h67, 0, lat, errk, nwe, nerr, bc, bad, pcn, tk);
      n_cmp++; if (tk !== exp[i]) begin n_fail++; $display("FAIL signed_sel%0d: got %b want %b", sels[i], tk, exp[i]); end
    end
    // zflag is inverted right after start inside run_jump; the captured value must rule.
    run_jump(1, 0, 1, 0, 0, 0, 'h0300, 'h45, 'h67, 0, lat, errk, nwe, nerr, bc, bad, pcn, tk);
    n_cmp++; if (pcn !== 16'h4567) begin n_fail++; $display("FAIL flag_capture: got %h want 4567", pcn); end
  endtask

  task automatic test_wait_timeout();
    int lat, errk, nwe, nerr, bc, bad; logic [15:0] pcn; logic tk;
    run_jump(0, 0, 0, 0, 0, 0, 'h0400, 'h55, 'hAA, 3, lat, errk, nwe, nerr, bc, bad, pcn, tk);
    n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL wait3_latency: got %0d want 9", lat); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL wait3_addr_stable: got %0d violations want 0", bad); end
    run_jump(0, 0, 0, 0, 0, 0, 'h0400, 'h55, 'hAA, 99, lat, errk, nwe, nerr, bc, bad, pcn, tk);
    n_cmp++; if (errk !== TO + 2) begin n_fail++; $display("FAIL timeout_err_cycle: got %0d want %0d", errk, TO + 2); end
    n_cmp++; if (nerr !== 1) begin n_fail++; $display("FAIL timeout_err_count: got %0d want 1", nerr); end
    n_cmp++; if (nwe !== 0) begin n_fail++; $display("FAIL timeout_pc_we: got %0d want 0", nwe); end
    run_jump(0, 0, 0, 0, 0, 0, 'h0400, 'h55, 'hAA, TO, lat, errk, nwe, nerr, bc, bad, pcn, tk);
    n_cmp++; if (nerr !== 0) begin n_fail++; $display("FAIL ack_at_limit_err: got %0d want 0", nerr); end
    n_cmp++; if (lat !== 3 + 2 * TO) begin n_fail++; $display("FAIL ack_at_limit_latency: got %0d want %0d", lat, 3 + 2 * TO); end
  endtask

  task automatic test_reset_mid_fetch();
    int nwe, nerr;
    logic [15:0] base;
    base = 16'h0500;
    @(negedge clk);
    mem[base] = 8'h11; mem[base + 16'd1] = 8'h22; ack_delay = 2;
    start = 1; cond_sel = 0; rel = 0; pc = base;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== base + 16'd1) begin
      n_fail++; $display("FAIL midrst_in_lo: got req %b addr %h want req 1 addr %h", mem_req, mem_addr, base + 16'd1); end
    rst = 0;
    @(negedge clk);
    n_cmp++; if ({mem_req, busy, pc_we, taken, err} !== 5'b0 || mem_addr !== 16'h0 || pc_next !== 16'h0) begin
      n_fail++; $display("FAIL midrst_outputs: got req %b busy %b we %b tk %b err %b addr %h pcn %h want all 0",
                         mem_req, busy, pc_we, taken, err, mem_addr, pc_next); end
    rst = 1;
    nwe = 0; nerr = 0;
    repeat (12) begin @(negedge clk); if (pc_we) nwe++; if (err) nerr++; end
    n_cmp++; if (nwe !== 0 || nerr !== 0) begin n_fail++; $display("FAIL midrst_no_pulse: got we %0d err %0d want 0 0", nwe, nerr); end
  endtask

  task automatic test_back_to_back_start();
    int nwe; logic [15:0] pcn, exp_pcn; bit exp_tk;
    model(2, 1, 0, 0, 0, 0, 'h0600, 'h01, 'h00, exp_tk, exp_pcn);
    @(negedge clk);
    mem[16'h0600] = 8'h01; mem[16'h0601] = 8'h00; ack_delay = 2;
    start = 1; cond_sel = 2; rel = 1; pc = 16'h0600;
    zflag = 0; oflag = 0; cflag = 0; sflag = 0;
    nwe = 0; pcn = 'x;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (pc_we) begin nwe++; pcn = pc_next; end
      start = (k <= 6) ? 1'($urandom % 2) : 1'b0;
      cond_sel = 4'($urandom); rel = 1'($urandom); pc = 16'($urandom); zflag = 1'($urandom);
    end
    n_cmp++; if (nwe !== 1) begin n_fail++; $display("FAIL busy_start_pc_we_count: got %0d want 1", nwe); end
    n_cmp++; if (pcn !== exp_pcn) begin n_fail++; $display("FAIL busy_start_pc_next: got %h want %h", pcn, exp_pcn); end
  endtask

  task automatic test_random();
    int lat, errk, nwe, nerr, bc, bad; logic [15:0] pcn; logic tk;
    int sel, p, hi, lo, dly; bit r, z, o, c, s, etk; logic [15:0] epcn;
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 15); r = 1'($urandom); z = 1'($urandom); o = 1'($urandom);
      c = 1'($urandom); s = 1'($urandom); p = $urandom_range(0, 65535);
      hi = $urandom_range(0, 255); lo = $urandom_range(0, 255); dly = $urandom_range(0, TO + 1);
      model(sel, r, z, o, c, s, p, hi, lo, etk, epcn);
      run_jump(sel, r, z, o, c, s, p, hi, lo, dly, lat, errk, nwe, nerr, bc, bad, pcn, tk);
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rnd%0d_protocol: got %0d violations want 0", n, bad); end
      if (dly > TO) begin
        n_cmp++; if (nwe !== 0 || nerr !== 1 || errk !== TO + 2) begin n_fail++;
          $display("FAIL rnd%0d_timeout: got we %0d err %0d at %0d want 0 1 at %0d", n, nwe, nerr, errk, TO + 2); end
      end else begin
        n_cmp++; if (nwe !== 1 || nerr !== 0 || lat !== 3 + 2 * dly) begin n_fail++;
          $display("FAIL rnd%0d_timing: got we %0d err %0d lat %0d want 1 0 %0d", n, nwe, nerr, lat, 3 + 2 * dly); end
        n_cmp++; if (tk !== etk || pcn !== epcn) begin n_fail++;
          $display("FAIL rnd%0d_result sel %0d rel %b: got tk %b pcn %h want tk %b pcn %h", n, sel, r, tk, pcn, etk, epcn); end
      end
    end
  endtask

  initial begin
    rst = 0; start = 0; cond_sel = 0; rel = 0; pc = 0;
    zflag = 0; oflag = 0; cflag = 0; sflag = 0;
    test_reset();
    test_abs_always();
    test_rel_wrap();
    test_not_taken();
    test_signed();
    test_wait_timeout();
    test_reset_mid_fetch();
    test_back_to_back_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
